ps2_key_decoder_fifo: RTL and testbench

//  Parametrised PS/2 scancode decoder with buffered output. Consumes byte strobes from the
//  PS/2 receiver, tracks make/break (F0) and extended (E0) prefixes, filters typematic

---
 rtl/ps2_key_decoder_fifo.sv | 143 ++++++++++++++
 tb/tb_ps2_key_decoder_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder_fifo.sv
// PS/2 scancode decoder: make/break/extended prefix tracking, typematic repeat filter,
// scancode-to-character mapping and a show-ahead FIFO with valid/ready output.
module ps2_key_decoder_fifo #(
   parameter int KEY_W         = 6,
   parameter int FIFO_DEPTH    = 8,
   parameter int REPEAT_FILTER = 1,
   parameter int ENABLE_EXT    = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [7:0]                      received_data,
   input  logic                            received_data_en,
   output logic [KEY_W-1:0]                key_data,
   output logic                            key_valid,
   input  logic                            key_ready,
   output logic                            key_pushed,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_level,
   output logic                            overflow
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

   function automatic logic [5:0] map_std(input logic [7:0] b);
      case (b)
         8'h1C: return 6'b000011;  8'h32: return 6'b000101;  8'h21: return 6'b000111;
         8'h23: return 6'b001001;  8'h24: return 6'b001011;  8'h2B: return 6'b001101;
         8'h34: return 6'b001111;  8'h33: return 6'b010001;  8'h43: return 6'b011001;
         8'h3B: return 6'b010101;  8'h42: return 6'b010111;  8'h4B: return 6'b010011;
         8'h3A: return 6'b011011;  8'h31: return 6'b011101;  8'h44: return 6'b011111;
         8'h4D: return 6'b100001;  8'h15: return 6'b100011;  8'h2D: return 6'b100101;
         8'h1B: return 6'b100111;  8'h2C: return 6'b101001;  8'h3C: return 6'b101011;
         8'h2A: return 6'b101101;  8'h1D: return 6'b101111;  8'h22: return 6'b110001;
         8'h35: return 6'b110011;  8'h1A: return 6'b110101;  8'h29: return 6'b000001;
         8'h5A: return 6'b111101;  8'h66: return 6'b111111;
         default: return 6'b000000;
      endcase
   endfunction

   function automatic logic [5:0] map_ext(input logic [7:0] b);
      case (b)
         8'h6B:   return 6'b111011;
         8'h74:   return 6'b111001;
         8'h71:   return 6'b111111;
         default: return 6'b000000;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [8:0]        held_q, held_d;
   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              key_pushed_q, key_pushed_d;
   logic [KEY_W-1:0]  mem_q [FIFO_DEPTH];

   logic              is_prefix, do_make, do_break, ev_ext, push, pop, full, push_ok;
   logic [5:0]        code;
   logic [8:0]        ev_key;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   assign is_prefix = (received_data == 8'hF0) || (received_data == 8'hE0);

   always_comb begin
      state_d = state_q;
      if (received_data_en) begin
         unique case (state_q)
            S_IDLE:    if (received_data == 8'hF0)      state_d = S_BRK;
                       else if (received_data == 8'hE0) state_d = S_EXT;
            S_BRK:     if (!is_prefix)                  state_d = S_IDLE;
            S_EXT:     if (received_data == 8'hF0)      state_d = S_EXT_BRK;
                       else if (received_data != 8'hE0) state_d = S_IDLE;
            S_EXT_BRK: if (!is_prefix)                  state_d = S_IDLE;
            default:                                    state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      ev_ext   = (state_q == S_EXT) || (state_q == S_EXT_BRK);
      do_make  = received_data_en && !is_prefix && ((state_q == S_IDLE) || (state_q == S_EXT));
      do_break = received_data_en && !is_prefix && ((state_q == S_BRK) || (state_q == S_EXT_BRK));
   end

   // Disabled extended keys decode to code 0 so they fall out as unmapped.
   always_comb begin
      ev_key = {ev_ext, received_data};
      code   = ev_ext ? ((ENABLE_EXT != 0) ? map_ext(received_data) : 6'b0) : map_std(received_data);
      held_d = held_q;
      push   = 1'b0;
      if (do_make && (code != 6'b0) && !((REPEAT_FILTER != 0) && (ev_key == held_q))) begin
         held_d = ev_key;
         push   = 1'b1;
      end else if (do_break && (ev_key == held_q)) begin
         held_d = 9'h000;
      end
   end

   always_comb begin
      full         = (count_q == CW'(FIFO_DEPTH));
      pop          = (count_q != '0) && key_ready;
      push_ok      = push && (!full || pop);
      wr_d         = push_ok ? wr_q + PW'(1) : wr_q;
      rd_d         = pop ? rd_q + PW'(1) : rd_q;
      count_d      = count_q + CW'(push_ok) - CW'(pop);
      overflow_d   = overflow_q | (push && full && !pop);
      key_pushed_d = push_ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q       <= 9'h000;
         wr_q         <= '0;
         rd_q         <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         key_pushed_q <= 1'b0;
      end else begin
         held_q       <= held_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         key_pushed_q <= key_pushed_d;
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= KEY_W'(code);
   end

   assign key_data   = (count_q != '0) ? mem_q[rd_q] : '0;
   assign key_valid  = (count_q != '0);
   assign key_pushed = key_pushed_q;
   assign fill_level = count_q;
   assign overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_key_decoder_fifo.sv
// Randomized + directed bench: two decoder configurations share one byte stream and are
// checked by a scoreboard fed from a prefix-flag reference model.
module tb_ps2_key_decoder_fifo;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_en = 1'b0;
   logic       kready = 1'b0;
   logic [5:0] kd  [2];
   logic       kv  [2];
   logic       kp  [2];
   logic       ovf [2];
   logic [3:0] fl  [2];

   always #5 clk = ~clk;

   ps2_key_decoder_fifo #(.KEY_W(6), .FIFO_DEPTH(DEPTH), .REPEAT_FILTER(1), .ENABLE_EXT(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .received_data(rx_data), .received_data_en(rx_en),
      .key_data(kd[0]), .key_valid(kv[0]), .key_ready(kready), .key_pushed(kp[0]),
      .fill_level(fl[0]), .overflow(ovf[0]));

   ps2_key_decoder_fifo #(.KEY_W(6), .FIFO_DEPTH(DEPTH), .REPEAT_FILTER(0), .ENABLE_EXT(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .received_data(rx_data), .received_data_en(rx_en),
      .key_data(kd[1]), .key_valid(kv[1]), .key_ready(kready), .key_pushed(kp[1]),
      .fill_level(fl[1]), .overflow(ovf[1]));

   int         checks = 0, failures = 0;
   int         rf [2] = '{1, 0};
   int         ee [2] = '{1, 0};
   int         mcnt [2], cur_cnt [2], npush [2], npop [2];
   bit         mbrk [2], mext [2], movf [2], mpush [2], cur_push [2], cur_ovf [2];
   logic [8:0] mheld [2];
   logic [5:0] q0 [$], q1 [$];
   logic [7:0] pool [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] ref_map(input bit ext, input logic [7:0] b);
      if (ext) begin
         case (b)
            8'h6B: return 6'b111011;  8'h74: return 6'b111001;  8'h71: return 6'b111111;
            default: return 6'b0;
         endcase
      end
      case (b)
         8'h1C: return 6'b000011;  8'h32: return 6'b000101;  8'h21: return 6'b000111;
         8'h23: return 6'b001001;  8'h24: return 6'b001011;  8'h2B: return 6'b001101;
         8'h34: return 6'b001111;  8'h33: return 6'b010001;  8'h43: return 6'b011001;
         8'h3B: return 6'b010101;  8'h42: return 6'b010111;  8'h4B: return 6'b010011;
         8'h3A: return 6'b011011;  8'h31: return 6'b011101;  8'h44: return 6'b011111;
         8'h4D: return 6'b100001;  8'h15: return 6'b100011;  8'h2D: return 6'b100101;
         8'h1B: return 6'b100111;  8'h2C: return 6'b101001;  8'h3C: return 6'b101011;
         8'h2A: return 6'b101101;  8'h1D: return 6'b101111;  8'h22: return 6'b110001;
         8'h35: return 6'b110011;  8'h1A: return 6'b110101;  8'h29: return 6'b000001;
         8'h5A: return 6'b111101;  8'h66: return 6'b111111;
         default: return 6'b0;
      endcase
   endfunction

   // Prefixes are tracked as two flags: "break pending" and "extended pending".
   task automatic model_step(input int i, input logic [7:0] b, input bit en, input bit rdy);
      bit         pop;
      logic [5:0] v;
      logic [8:0] k;
      pop = (mcnt[i] > 0) && rdy;
      v = 6'b0;
      mpush[i] = 1'b0;
      if (en) begin
         if (b == 8'hF0) mbrk[i] = 1'b1;
         else if (b == 8'hE0) begin
            if (!mbrk[i]) mext[i] = 1'b1;
         end else begin
            k = {mext[i], b};
            if (mbrk[i]) begin
               if (k == mheld[i]) mheld[i] = 9'h0;
            end else begin
               v = (mext[i] && ee[i] == 0) ? 6'b0 : ref_map(mext[i], b);
               if (v != 0 && !(rf[i] != 0 && k == mheld[i])) mheld[i] = k;
               else v = 6'b0;
            end
            mbrk[i] = 1'b0;
            mext[i] = 1'b0;
         end
      end
      if (v != 0) begin
         if (mcnt[i] == DEPTH && !pop) movf[i] = 1'b1;
         else begin
            mpush[i] = 1'b1;
            mcnt[i]++;
            if (i == 0) q0.push_back(v); else q1.push_back(v);
         end
      end
      if (pop) mcnt[i]--;
   endtask

   task automatic cycle(input logic [7:0] b, input bit en, input bit rdy);
      rx_data = b; rx_en = en; kready = rdy;
      for (int i = 0; i < 2; i++) model_step(i, b, en, rdy);
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         cur_cnt[i] = mcnt[i]; cur_push[i] = mpush[i]; cur_ovf[i] = movf[i];
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int j = 0; j < n; j++) cycle(8'h00, 1'b0, rdy);
   endtask

   task automatic do_reset();
      rx_en = 1'b0; kready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("dut%0d.rst_key_data", i), kd[i], 0);
         chk($sformatf("dut%0d.rst_key_valid", i), kv[i], 0);
         chk($sformatf("dut%0d.rst_key_pushed", i), kp[i], 0);
         chk($sformatf("dut%0d.rst_fill_level", i), fl[i], 0);
         chk($sformatf("dut%0d.rst_overflow", i), ovf[i], 0);
         mcnt[i] = 0; cur_cnt[i] = 0; mbrk[i] = 0; mext[i] = 0; mheld[i] = 9'h0;
         movf[i] = 0; cur_ovf[i] = 0; mpush[i] = 0; cur_push[i] = 0;
      end
      q0.delete(); q1.delete();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d.fill_level", i), fl[i], cur_cnt[i]);
            chk($sformatf("dut%0d.key_valid", i), kv[i], cur_cnt[i] > 0);
            chk($sformatf("dut%0d.key_pushed", i), kp[i], cur_push[i]);
            chk($sformatf("dut%0d.overflow", i), ovf[i], cur_ovf[i]);
            if (kp[i] === 1'b1) npush[i]++;
            if (kv[i] === 1'b1 && kready) begin
               npop[i]++;
               if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                  checks++; failures++;
                  $display("FAIL dut%0d.unexpected_pop actual=%0h required=none", i, kd[i]);
               end else if (i == 0) chk("dut0.key_data", kd[0], q0.pop_front());
               else chk("dut1.key_data", kd[1], q1.pop_front());
            end else if (kv[i] !== 1'b1) begin
               chk($sformatf("dut%0d.key_data_empty", i), kd[i], 0);
            end
         end
      end
   end

   initial begin
      int p0, p1;
      logic [7:0] seq [9];
      logic [7:0] b;
      bit en, rdy;
      pool = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42,
               8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
               8'h1D, 8'h22, 8'h35, 8'h1A, 8'h29, 8'h5A, 8'h66, 8'h6B, 8'h74, 8'h71};
      seq = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
      for (int i = 0; i < 2; i++) begin npush[i] = 0; npop[i] = 0; end
      do_reset();

      // T1: make, break, make again -> held cleared between
      p0 = npush[0]; p1 = npop[0];
      cycle(8'h1C, 1, 1); cycle(8'hF0, 1, 1); cycle(8'h1C, 1, 1); idle(3, 1);
      chk("t1_pushes", npush[0] - p0, 1);
      chk("t1_pops", npop[0] - p1, 1);
      cycle(8'h1C, 1, 1); idle(3, 1);
      chk("t1_repush_after_break", npush[0] - p0, 2);
      cycle(8'hF0, 1, 1); cycle(8'h1C, 1, 1);

      // T2: typematic repeat filter
      p0 = npush[0]; p1 = npush[1];
      cycle(8'h15, 1, 1); cycle(8'h15, 1, 1); cycle(8'h15, 1, 1); cycle(8'hF0, 1, 1);
      cycle(8'h15, 1, 1); cycle(8'h15, 1, 1); idle(3, 1);
      chk("t2_filtered_pushes", npush[0] - p0, 2);
      chk("t2_unfiltered_pushes", npush[1] - p1, 4);
      cycle(8'hF0, 1, 1); cycle(8'h15, 1, 1);

      // T3: extended key press/release
      p0 = npush[0]; p1 = npush[1];
      cycle(8'hE0, 1, 1); cycle(8'h6B, 1, 1); cycle(8'hE0, 1, 1); cycle(8'hF0, 1, 1);
      cycle(8'h6B, 1, 1); idle(3, 1);
      chk("t3_ext_pushes", npush[0] - p0, 1);
      chk("t3_ext_disabled_pushes", npush[1] - p1, 0);
      p1 = npush[1];
      cycle(8'h1C, 1, 1); idle(3, 1);
      chk("t3_fsm_back_idle", npush[1] - p1, 1);

      // T4: overflow then ordered drain
      do_reset();
      for (int j = 0; j < 9; j++) cycle(seq[j], 1, 0);
      idle(2, 0);
      chk("t4_fill_full", fl[0], 8);
      chk("t4_overflow", ovf[0], 1);
      idle(8, 1);
      chk("t4_valid_drained", kv[0], 0);
      idle(2, 1);

      // T5: full FIFO with simultaneous push and pop
      do_reset();
      for (int j = 0; j < 8; j++) cycle(seq[j], 1, 0);
      cycle(8'h3B, 1, 1);
      chk("t5_fill_stays", fl[0], 8);
      chk("t5_no_overflow", ovf[0], 0);
      idle(10, 1);

      // T6: reset after F0 prefix with a queued entry
      cycle(8'h1C, 1, 0); cycle(8'hF0, 1, 0);
      do_reset();
      p0 = npush[0];
      cycle(8'h1C, 1, 1); idle(3, 1);
      chk("t6_push_after_reset", npush[0] - p0, 1);

      // Random stream with slow-consumer windows to exercise overflow
      for (int c = 0; c < 4000; c++) begin
         case ($urandom_range(0, 9))
            0, 1:    b = 8'hF0;
            2:       b = 8'hE0;
            3:       b = 8'($urandom_range(0, 255));
            default: b = pool[$urandom_range(0, 31)];
         endcase
         en  = ($urandom_range(0, 1) == 1);
         rdy = ((c / 300) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         cycle(b, en, rdy);
         if (c % 1000 == 999) do_reset();
      end
      idle(20, 1);
      chk("end_q0_empty", q0.size(), 0);
      chk("end_q1_empty", q1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
